// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: memory-stage sequencer state and helpers.
package lc3b_types;

   typedef enum logic [1:0] {
      MEM_IDLE   = 2'd0,
      MEM_PTR    = 2'd1,
      MEM_ACCESS = 2'd2
   } lc3b_mem_state;

   localparam logic [1:0] BE_WORD = 2'b11;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-cache sequencer: drives the cache port, stalls the pipe until
// the access completes, and runs the pointer fetch for LDI/STI.
module mem_stage_ctrl
   import lc3b_types::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              indirect_enable,
   input  logic [1:0]        mem_byte_enable,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              dmem_resp,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [ADDR_W-1:0] dmem_address,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [1:0]        dmem_byte_enable,
   output logic              stall,
   output logic [DATA_W-1:0] rdata_out,
   output logic [15:0]       stall_count
);

   lc3b_mem_state     state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        be_q;
   logic              write_q;
   logic [15:0]       cnt_q;
   logic              req;
   logic              done;

   assign req  = valid & (mem_read | mem_write);
   // A reset coinciding with the final response abandons the access.
   assign done = (state_q == MEM_ACCESS) & dmem_resp & ~rst;

   always_comb begin
      state_d          = state_q;
      stall            = 1'b0;
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      dmem_byte_enable = be_q;
      case (state_q)
         MEM_IDLE: begin
            stall = req;
            if (req)
               state_d = indirect_enable ? MEM_PTR : MEM_ACCESS;
         end
         MEM_PTR: begin
            stall            = 1'b1;
            dmem_read        = 1'b1;
            dmem_byte_enable = BE_WORD;
            if (dmem_resp)
               state_d = MEM_ACCESS;
         end
         MEM_ACCESS: begin
            stall      = ~dmem_resp;
            dmem_read  = ~write_q;
            dmem_write = write_q;
            if (dmem_resp)
               state_d = MEM_IDLE;
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   assign dmem_address = {addr_q[ADDR_W-1:1], 1'b0};
   assign dmem_wdata   = wdata_q;
   assign rdata_out    = (done & ~write_q) ? dmem_rdata : rdata_q;
   assign stall_count  = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MEM_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= BE_WORD;
         write_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (stall)
            cnt_q <= sat_inc16(cnt_q);
         case (state_q)
            MEM_IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  be_q    <= mem_byte_enable;
                  write_q <= mem_write;
               end
            end
            MEM_PTR: begin
               // The fetched pointer becomes the target; indirect accesses are word-only.
               if (dmem_resp) begin
                  addr_q <= ADDR_W'(dmem_rdata);
                  be_q   <= BE_WORD;
               end
            end
            MEM_ACCESS: begin
               if (dmem_resp & ~write_q)
                  rdata_q <= dmem_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl against a transaction-level memory model.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, mem_read, mem_write, indirect_enable;
   logic [1:0]  mem_byte_enable;
   logic [15:0] addr, wdata;
   logic        dmem_resp;
   logic [15:0] dmem_rdata;
   logic        dmem_read, dmem_write;
   logic [15:0] dmem_address, dmem_wdata;
   logic [1:0]  dmem_byte_enable;
   logic        stall;
   logic [15:0] rdata_out, stall_count;

   always #5 clk = ~clk;

   mem_stage_ctrl dut (
      .clk(clk), .rst(rst), .valid(valid), .mem_read(mem_read),
      .mem_write(mem_write), .indirect_enable(indirect_enable),
      .mem_byte_enable(mem_byte_enable), .addr(addr), .wdata(wdata),
      .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
      .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
      .dmem_byte_enable(dmem_byte_enable), .stall(stall),
      .rdata_out(rdata_out), .stall_count(stall_count)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [15:0] mem [logic [15:0]];
   int          cnt_m;
   logic [15:0] last_rd;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   function automatic logic [15:0] mrd(input logic [15:0] a);
      if (!mem.exists(a)) mem[a] = 16'($urandom);
      return mem[a];
   endfunction

   task automatic scramble();
      valid           = 1'($urandom);
      mem_read        = 1'($urandom);
      mem_write       = 1'($urandom);
      indirect_enable = 1'($urandom);
      mem_byte_enable = 2'($urandom);
      addr            = 16'($urandom);
      wdata           = 16'($urandom);
   endtask

   task automatic step(input string tg, input logic er, input logic ew,
                       input logic [15:0] ea, input logic [1:0] eb,
                       input bit cw, input logic [15:0] ewd, input logic es);
      chk({tg, "_rd"}, dmem_read, er);
      chk({tg, "_wr"}, dmem_write, ew);
      chk({tg, "_addr"}, dmem_address, ea);
      chk({tg, "_be"}, dmem_byte_enable, eb);
      if (cw) chk({tg, "_wdata"}, dmem_wdata, ewd);
      chk({tg, "_stall"}, stall, es);
      chk({tg, "_cnt"}, stall_count, cnt_m);
      if (es) cnt_m = sat(cnt_m + 1);
   endtask

   task automatic chk_reset_vals(input string tg);
      chk({tg, "_rd"}, dmem_read, 0);
      chk({tg, "_wr"}, dmem_write, 0);
      chk({tg, "_addr"}, dmem_address, 0);
      chk({tg, "_wdata"}, dmem_wdata, 0);
      chk({tg, "_be"}, dmem_byte_enable, 2'b11);
      chk({tg, "_stall"}, stall, 0);
      chk({tg, "_rdata"}, rdata_out, 0);
      chk({tg, "_cnt"}, stall_count, 0);
      cnt_m   = 0;
      last_rd = 16'h0;
   endtask

   // One instruction: accept cycle, optional pointer read (l1 cycles), final access (l2 cycles).
   task automatic run_txn(input bit wr, input bit ind, input logic [1:0] be,
                          input logic [15:0] a, input logic [15:0] wd,
                          input int l1, input int l2);
      logic [15:0] aa, tgt, rv, old;
      logic [1:0]  ebe;
      @(negedge clk);
      valid = 1'b1; mem_read = !wr; mem_write = wr; indirect_enable = ind;
      mem_byte_enable = be; addr = a; wdata = wd;
      dmem_resp = 1'b0; dmem_rdata = 16'($urandom);
      #1;
      step("accept", 1'b0, 1'b0, dmem_address, dmem_byte_enable, 1'b0, 16'h0, 1'b1);
      tgt = a;
      rv  = 16'h0;
      if (ind) begin
         aa = {a[15:1], 1'b0};
         rv = mrd(aa);
         for (int c = 1; c <= l1; c++) begin
            @(negedge clk);
            scramble();
            dmem_resp  = (c == l1);
            dmem_rdata = (c == l1) ? rv : 16'($urandom);
            #1;
            step("ptr", 1'b1, 1'b0, aa, 2'b11, 1'b0, 16'h0, 1'b1);
            chk("ptr_rdata_hold", rdata_out, last_rd);
         end
         tgt = rv;
      end
      aa  = {tgt[15:1], 1'b0};
      ebe = ind ? 2'b11 : be;
      if (!wr) rv = mrd(aa);
      else begin
         old = mrd(aa);
         mem[aa] = {ebe[1] ? wd[15:8] : old[15:8], ebe[0] ? wd[7:0] : old[7:0]};
      end
      for (int c = 1; c <= l2; c++) begin
         @(negedge clk);
         scramble();
         dmem_resp  = (c == l2);
         dmem_rdata = (c == l2 && !wr) ? rv : 16'($urandom);
         #1;
         step("acc", !wr, wr, aa, ebe, wr, wd, c != l2);
         if (c == l2 && !wr) begin
            chk("rdata_done", rdata_out, rv);
            last_rd = rv;
         end else if (c != l2) begin
            chk("acc_rdata_hold", rdata_out, last_rd);
         end
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      valid = 1'($urandom);
      if (valid) begin mem_read = 1'b0; mem_write = 1'b0; end
      else begin mem_read = 1'($urandom); mem_write = 1'($urandom); end
      indirect_enable = 1'($urandom);
      addr = 16'($urandom); wdata = 16'($urandom);
      dmem_resp = 1'($urandom); dmem_rdata = 16'($urandom);
      #1;
      chk("bubble_stall", stall, 0);
      chk("bubble_rd", dmem_read, 0);
      chk("bubble_wr", dmem_write, 0);
      chk("bubble_rdata", rdata_out, last_rd);
      chk("bubble_cnt", stall_count, cnt_m);
   endtask

   // Direct read abandoned by reset after two wait cycles of a long cache wait.
   task automatic reset_in_access(input bit with_resp, input logic [15:0] a);
      logic [15:0] aa;
      aa = {a[15:1], 1'b0};
      @(negedge clk);
      valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; indirect_enable = 1'b0;
      mem_byte_enable = 2'b11; addr = a; dmem_resp = 1'b0;
      #1;
      step("rst_accept", 1'b0, 1'b0, dmem_address, dmem_byte_enable, 1'b0, 16'h0, 1'b1);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         scramble();
         dmem_resp = 1'b0;
         #1;
         step("rst_wait", 1'b1, 1'b0, aa, 2'b11, 1'b0, 16'h0, 1'b1);
      end
      @(negedge clk);
      rst = 1'b1; dmem_resp = with_resp; dmem_rdata = 16'hC0DE;
      #1;
      if (with_resp) chk("rst_resp_rdata", rdata_out, last_rd);
      @(negedge clk);
      rst = 1'b0; valid = 1'b0; dmem_resp = 1'b0;
      #1;
      chk_reset_vals("after_rst");
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      indirect_enable = 1'b0; mem_byte_enable = 2'b00; addr = 16'h0; wdata = 16'h0;
      dmem_resp = 1'b0; dmem_rdata = 16'h0;
      cnt_m = 0; last_rd = 16'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; valid = 1'b0;
      #1;
      chk_reset_vals("reset");

      // directed cases
      mem[16'h1234] = 16'hBEEF;
      run_txn(1'b0, 1'b0, 2'b11, 16'h1235, 16'h0000, 0, 1);
      chk("ldr_cnt", stall_count, 1);
      run_txn(1'b1, 1'b0, 2'b10, 16'h2000, 16'hAB00, 0, 3);
      mem[16'h0040] = 16'h3000;
      mem[16'h3000] = 16'h0007;
      run_txn(1'b0, 1'b1, 2'b01, 16'h0040, 16'h0000, 1, 1);
      chk("ldi_result", last_rd, 16'h0007);
      mem[16'h0040] = 16'h3001;
      run_txn(1'b1, 1'b1, 2'b01, 16'h0040, 16'h5A5A, 2, 2);
      chk("sti_mem", mem[16'h3000], 16'h5A5A);
      idle_cycle();
      idle_cycle();

      // reset mid-access, then a normal load
      reset_in_access(1'b0, 16'h0100);
      run_txn(1'b0, 1'b0, 2'b11, 16'h1235, 16'h0000, 0, 1);
      run_txn(1'b0, 1'b0, 2'b11, 16'h0202, 16'h0000, 0, 2);
      reset_in_access(1'b1, 16'h0300);
      run_txn(1'b0, 1'b1, 2'b11, 16'h0040, 16'h0000, 3, 1);

      // randomized traffic, back-to-back and with bubbles
      for (int i = 0; i < 60; i++) begin
         bit          w, ind;
         int          gaps;
         w    = 1'($urandom);
         ind  = ($urandom_range(0, 3) == 0);
         run_txn(w, ind, 2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
                 $urandom_range(1, 4), $urandom_range(1, 4));
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) idle_cycle();
      end

      // saturation via one very long cache wait
      @(negedge clk);
      rst = 1'b1; valid = 1'b0; dmem_resp = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_vals("pre_sat");
      run_txn(1'b0, 1'b0, 2'b11, 16'h0500, 16'h0000, 0, 65540);
      chk("sat_cnt", stall_count, 16'hFFFF);
      run_txn(1'b1, 1'b0, 2'b11, 16'h0600, 16'h1234, 0, 3);
      idle_cycle();
      chk("sat_hold", stall_count, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
